// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encoding and counter width helper for serial_adder
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int cnt_w(int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/fa_bit.sv
// fa_bit: single-bit full adder; x,y,ci in -> s sum, co carry out
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial a+b+c_in with start/busy/done; sum/c_out valid from done until next accepted start
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int CW = cnt_w(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0] cnt;
  logic carry, s, co, last, accept;
  fa_bit u_fa (.x(a_sh[0]), .y(b_sh[0]), .ci(carry), .s(s), .co(co));
  assign last   = cnt == CW'(WIDTH - 1);
  assign accept = start && state != RUN;
  assign busy   = state == RUN;
  assign done   = state == DONE;
  assign c_out  = carry;
  always_comb begin
    state_nx = state;
    state_nx = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      sum   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= c_in;
      cnt   <= '0;
    end else if (state == RUN) begin
      sum   <= (sum >> 1) | (WIDTH'(s) << (WIDTH - 1));
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= co;
      cnt   <= last ? '0 : cnt + 1'b1;
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table-driven checks of serial_adder at WIDTH=8 and WIDTH=1
module tb_serial_adder;
  typedef struct {
    logic [7:0] a, b;
    logic       ci;
    logic [7:0] s;
    logic       co;
  } vec_t;
  logic clk = 0, rst_n = 0;
  logic start8 = 0, ci8 = 0, start1 = 0, a1 = 0, b1 = 0, ci1 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic busy8, done8, co8, busy1, done1, s1, co1;
  logic [7:0] s8;
  int errors = 0, checks = 0;
  vec_t v8[6];
  vec_t v1[8];
  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .c_in(ci8),
    .busy(busy8), .done(done8), .sum(s8), .c_out(co8)
  );
  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .c_in(ci1),
    .busy(busy1), .done(done1), .sum(s1), .c_out(co1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    a8 = a; b8 = b; ci8 = ci; start8 = 1;
    @(negedge clk);
    start8 = 0;
  endtask
  task automatic wait8(output int n);
    n = 0;
    while (busy8 && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask
  task automatic check_result(input string nm, input logic [7:0] es, input logic ec);
    chk({nm, " done"}, done8, 1);
    chk({nm, " sum"}, s8, es);
    chk({nm, " c_out"}, co8, ec);
  endtask
  initial begin
    int n;
    logic saw;
    v8[0] = '{8'h5A, 8'h3C, 0, 8'h96, 0};
    v8[1] = '{8'hFF, 8'h01, 0, 8'h00, 1};
    v8[2] = '{8'hFF, 8'hFF, 1, 8'hFF, 1};
    v8[3] = '{8'h00, 8'h00, 0, 8'h00, 0};
    v8[4] = '{8'h80, 8'h80, 1, 8'h01, 1};
    v8[5] = '{8'h7F, 8'h01, 0, 8'h80, 0};
    v1[0] = '{0, 0, 0, 0, 0};
    v1[1] = '{0, 0, 1, 1, 0};
    v1[2] = '{0, 1, 0, 1, 0};
    v1[3] = '{0, 1, 1, 0, 1};
    v1[4] = '{1, 0, 0, 1, 0};
    v1[5] = '{1, 0, 1, 0, 1};
    v1[6] = '{1, 1, 0, 0, 1};
    v1[7] = '{1, 1, 1, 1, 1};
    repeat (3) @(negedge clk);
    chk("rst busy", busy8, 0);
    chk("rst done", done8, 0);
    chk("rst sum", s8, 0);
    chk("rst c_out", co8, 0);
    rst_n = 1;
    @(negedge clk);
    chk("post-rst busy", busy8, 0);
    chk("post-rst sum", s8, 0);
    for (int i = 0; i < 6; i++) begin
      launch8(v8[i].a, v8[i].b, v8[i].ci);
      wait8(n);
      chk($sformatf("v%0d busy_len", i), n, 8);
      check_result($sformatf("v%0d", i), v8[i].s, v8[i].co);
      @(negedge clk);
      chk($sformatf("v%0d idle done", i), done8, 0);
      chk($sformatf("v%0d idle busy", i), busy8, 0);
      chk($sformatf("v%0d hold sum", i), s8, v8[i].s);
      chk($sformatf("v%0d hold c_out", i), co8, v8[i].co);
    end
    launch8(8'h01, 8'h02, 0);
    repeat (2) @(negedge clk);
    a8 = 8'h11; start8 = 1;
    @(negedge clk);
    start8 = 0;
    wait8(n);
    chk("ignore busy_len", n, 5);
    check_result("ignore", 8'h03, 0);
    launch8(8'h10, 8'h20, 0);
    chk("b2b busy", busy8, 1);
    chk("b2b done", done8, 0);
    wait8(n);
    chk("b2b busy_len", n, 8);
    check_result("b2b", 8'h30, 0);
    @(negedge clk);
    launch8(8'hFF, 8'hFF, 1);
    repeat (3) @(negedge clk);
    chk("pre-abort busy", busy8, 1);
    #2 rst_n = 0;
    #1;
    chk("abort busy", busy8, 0);
    chk("abort done", done8, 0);
    chk("abort sum", s8, 0);
    chk("abort c_out", co8, 0);
    @(negedge clk);
    rst_n = 1;
    saw = 0;
    repeat (12) begin
      @(negedge clk);
      saw |= done8 | busy8;
    end
    chk("abort no done", saw, 0);
    chk("abort sum held", s8, 0);
    launch8(8'h5A, 8'h3C, 1);
    wait8(n);
    chk("fresh busy_len", n, 8);
    check_result("fresh", 8'h97, 0);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      a1 = v1[i].a[0]; b1 = v1[i].b[0]; ci1 = v1[i].ci; start1 = 1;
      @(negedge clk);
      start1 = 0;
      chk($sformatf("w1 v%0d busy", i), busy1, 1);
      chk($sformatf("w1 v%0d early done", i), done1, 0);
      @(negedge clk);
      chk($sformatf("w1 v%0d done", i), done1, 1);
      chk($sformatf("w1 v%0d sum", i), s1, v1[i].s[0]);
      chk($sformatf("w1 v%0d c_out", i), co1, v1[i].co);
      @(negedge clk);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
